// File: rtl/rom_fetch_pkg.sv
// Shared encodings for the ROM fetch arbiter: transfer sizes, FSM states, owners.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package rom_fetch_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BEAT0 = 3'd1,
        ST_BEAT1 = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DL = 1'b1
    } owner_e;

    // The reserved size code fetches a full word.
    function automatic logic is_word(input logic [1:0] sz);
        return (sz == SZ_WORD) || (sz == SZ_RSVD);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input arbiter (IF vs DL) with last-grant register; FAIR=0 forces IF priority.
// Latency: combinational grant; last-grant updates on the edge where take is high.
// Backpressure: none; the caller decides when a grant is taken.
//
// Ports:
//   clk, reset      clock, async active-low reset (last-grant resets to DL)
//   req_if, req_dl  candidate requests
//   take            the caller consumes the grant this cycle
//   gnt_vld         at least one request is present
//   gnt_own         winner (0 = IF, 1 = DL)
module rr_arbiter2
    import rom_fetch_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic req_if,
    input  logic req_dl,
    input  logic take,
    output logic gnt_vld,
    output logic gnt_own
);

    owner_e last_q;
    owner_e win;

    always_comb begin
        win = OWN_IF;
        if (req_if && req_dl) begin
            // Contention: the side that did not win last time goes first.
            win = (FAIR && (last_q == OWN_IF)) ? OWN_DL : OWN_IF;
        end else if (req_dl) begin
            win = OWN_DL;
        end
    end

    assign gnt_vld = req_if | req_dl;
    assign gnt_own = win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= OWN_DL;
        end else if (take && gnt_vld) begin
            last_q <= win;
        end
    end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Shares a dual-port byte ROM between IF and DL, assembling LE byte/half/word results.
// Latency: ack in the cycle after grant edge +2 (byte/half) or +3 (word); ack lasts one cycle.
// Backpressure: requesters hold req until their ack; a new grant may close the ack cycle.
//
// Ports:
//   clk, reset                  clock, async active-low reset
//   if_req/if_addr/if_ack       instruction fetch requester (always word)
//   dl_req/dl_addr/dl_size/dl_ack  data load requester
//   rdata                       assembled, zero-extended result; valid while an ack is high
//   busy                        transfer in progress (any state but IDLE)
//   rom_addr/rom_addr_a         registered ROM addresses (ports 0 and A)
//   rom_data/rom_data_a         ROM read data, one cycle after the address
module rom_fetch_arbiter
    import rom_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter bit FAIR       = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    input  logic                  dl_req,
    input  logic [ADDR_WIDTH-1:0] dl_addr,
    input  logic [1:0]            dl_size,
    output logic                  dl_ack,
    output logic [31:0]           rdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [ADDR_WIDTH-1:0] rom_addr_a,
    input  logic [7:0]            rom_data,
    input  logic [7:0]            rom_data_a
);

    state_e                  state_q;
    state_e                  state_d;
    owner_e                  own_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]              size_q;
    logic                    word_q;

    logic                    grant_win;
    logic                    if_req_m;
    logic                    dl_req_m;
    logic                    gnt_vld;
    logic                    gnt_own;
    logic                    gnt;
    logic [ADDR_WIDTH-1:0]   gnt_addr;
    logic [1:0]              gnt_size;

    assign word_q = is_word(size_q);

    // The requester being acked still shows req at the DONE closing edge;
    // mask it so the finished transfer is not granted a second time.
    assign if_req_m = if_req & ~((state_q == ST_DONE) && (own_q == OWN_IF));
    assign dl_req_m = dl_req & ~((state_q == ST_DONE) && (own_q == OWN_DL));

    rr_arbiter2 #(
        .FAIR (FAIR)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_if  (if_req_m),
        .req_dl  (dl_req_m),
        .take    (grant_win),
        .gnt_vld (gnt_vld),
        .gnt_own (gnt_own)
    );

    assign gnt      = grant_win & gnt_vld;
    assign gnt_addr = (gnt_own == OWN_IF) ? if_addr : dl_addr;
    assign gnt_size = (gnt_own == OWN_IF) ? 2'(SZ_WORD) : dl_size;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: state_d = gnt ? ST_BEAT0 : ST_IDLE;
            ST_BEAT0:         state_d = word_q ? ST_BEAT1 : ST_WAIT;
            ST_BEAT1:         state_d = ST_WAIT;
            ST_WAIT:          state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy      = 1'b1;
        grant_win = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy      = 1'b0;
                grant_win = 1'b1;
            end
            ST_DONE: grant_win = 1'b1;
            default: ;
        endcase
    end

    // Datapath: latched request, ROM addresses, byte assembly, acks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            own_q      <= OWN_IF;
            addr_q     <= '0;
            size_q     <= '0;
            rom_addr   <= '0;
            rom_addr_a <= '0;
            rdata      <= '0;
            if_ack     <= 1'b0;
            dl_ack     <= 1'b0;
        end else begin
            if_ack <= (state_q == ST_WAIT) && (own_q == OWN_IF);
            dl_ack <= (state_q == ST_WAIT) && (own_q == OWN_DL);

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (gnt) begin
                        own_q      <= owner_e'(gnt_own);
                        addr_q     <= gnt_addr;
                        size_q     <= gnt_size;
                        rom_addr   <= gnt_addr;
                        rom_addr_a <= gnt_addr + ADDR_WIDTH'(1);
                    end
                end
                ST_BEAT0: begin
                    // Byte/half leave the ports parked; the second pair is never read.
                    if (word_q) begin
                        rom_addr   <= addr_q + ADDR_WIDTH'(2);
                        rom_addr_a <= addr_q + ADDR_WIDTH'(3);
                    end
                end
                ST_BEAT1: begin
                    rdata[15:0] <= {rom_data_a, rom_data};
                end
                ST_WAIT: begin
                    case (size_q)
                        SZ_BYTE: rdata <= {24'd0, rom_data};
                        SZ_HALF: rdata <= {16'd0, rom_data_a, rom_data};
                        default: rdata[31:16] <= {rom_data_a, rom_data};
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
module tb_rom_fetch_arbiter;

    logic clk;
    logic reset;

    logic [1:0]       if_req;
    logic [1:0][31:0] if_addr;
    logic [1:0]       dl_req;
    logic [1:0][31:0] dl_addr;
    logic [1:0][1:0]  dl_size;
    logic [1:0]       if_ack;
    logic [1:0]       dl_ack;
    logic [1:0]       busy;
    logic [1:0][31:0] rdata;
    logic [1:0][31:0] rom_addr;
    logic [1:0][31:0] rom_addr_a;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Instance 0: round-robin. Instance 1: fixed IF priority.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0] rd;
        logic [7:0] rda;

        // Behavioural ROM: byte[a] = a[7:0], one cycle read latency.
        always @(posedge clk) begin
            rd  <= rom_addr[g][7:0];
            rda <= rom_addr_a[g][7:0];
        end

        rom_fetch_arbiter #(
            .ADDR_WIDTH (32),
            .FAIR       ((g == 0) ? 1'b1 : 1'b0)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .if_req     (if_req[g]),
            .if_addr    (if_addr[g]),
            .if_ack     (if_ack[g]),
            .dl_req     (dl_req[g]),
            .dl_addr    (dl_addr[g]),
            .dl_size    (dl_size[g]),
            .dl_ack     (dl_ack[g]),
            .rdata      (rdata[g]),
            .busy       (busy[g]),
            .rom_addr   (rom_addr[g]),
            .rom_addr_a (rom_addr_a[g]),
            .rom_data   (rd),
            .rom_data_a (rda)
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d: got %h want %h", name, g, cyc, act, exp);
        end
    endtask

    // ---------------- Transaction-level model ----------------
    // m_left: busy cycles remaining (0 = idle, 1 = the ack cycle).
    int          m_left [2];
    int          m_lat  [2];
    bit          m_own  [2];   // 0 = IF, 1 = DL
    bit          m_last [2];
    bit          m_word [2];
    logic [31:0] m_ra   [2];
    logic [31:0] m_raa  [2];
    logic [31:0] m_data [2];

    function automatic logic [31:0] rom_value(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] a1, a2, a3;
        a1 = a + 32'd1;
        a2 = a + 32'd2;
        a3 = a + 32'd3;
        if (sz == 2'd0) return {24'd0, a[7:0]};
        if (sz == 2'd1) return {16'd0, a1[7:0], a[7:0]};
        return {a3[7:0], a2[7:0], a1[7:0], a[7:0]};
    endfunction

    task automatic model_reset(input int g);
        m_left[g] = 0;
        m_lat[g]  = 0;
        m_own[g]  = 1'b0;
        m_last[g] = 1'b1;
        m_word[g] = 1'b0;
        m_ra[g]   = 32'd0;
        m_raa[g]  = 32'd0;
        m_data[g] = 32'd0;
    endtask

    task automatic model_step(input int g);
        bit ack_now, free, eif, edl, pick_if;
        logic [31:0] a;
        logic [1:0]  sz;
        ack_now = (m_left[g] == 1);
        free    = (m_left[g] <= 1);
        eif     = if_req[g] && !(ack_now && m_own[g] == 1'b0);
        edl     = dl_req[g] && !(ack_now && m_own[g] == 1'b1);
        if (free && (eif || edl)) begin
            pick_if   = eif && (!edl || g == 1 || m_last[g] == 1'b1);
            m_own[g]  = !pick_if;
            m_last[g] = !pick_if;
            a         = pick_if ? if_addr[g] : dl_addr[g];
            sz        = pick_if ? 2'd2 : dl_size[g];
            m_word[g] = (sz >= 2'd2);
            m_lat[g]  = m_word[g] ? 3 : 2;
            m_left[g] = m_lat[g] + 1;
            m_ra[g]   = a;
            m_raa[g]  = a + 32'd1;
            m_data[g] = rom_value(a, sz);
        end else begin
            if (m_left[g] > 0) m_left[g]--;
            if (m_word[g] && m_left[g] == m_lat[g]) begin
                m_ra[g]  = m_ra[g] + 32'd2;
                m_raa[g] = m_raa[g] + 32'd2;
            end
        end
    endtask

    initial begin
        for (int g = 0; g < 2; g++) model_reset(g);
        forever begin
            @(posedge clk or negedge reset);
            for (int g = 0; g < 2; g++) begin
                if (!reset) model_reset(g);
                else        model_step(g);
            end
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                chk("busy",       g, 32'(busy[g]),   32'(m_left[g] > 0));
                chk("if_ack",     g, 32'(if_ack[g]), 32'(m_left[g] == 1 && m_own[g] == 1'b0));
                chk("dl_ack",     g, 32'(dl_ack[g]), 32'(m_left[g] == 1 && m_own[g] == 1'b1));
                chk("rom_addr",   g, rom_addr[g],    m_ra[g]);
                chk("rom_addr_a", g, rom_addr_a[g],  m_raa[g]);
                if (m_left[g] == 1) chk("rdata", g, rdata[g], m_data[g]);
            end
        end
    end

    // ---------------- Requester driver ----------------
    // Holds req until ack, keeps it up through the ack-closing edge, then drops.
    task automatic do_req(input int g, input bit is_if, input logic [31:0] a,
                          input logic [1:0] sz, input logic [31:0] exp, input bit chg);
        bit got;
        got = 1'b0;
        @(negedge clk);
        if (is_if) begin
            if_addr[g] = a;
            if_req[g]  = 1'b1;
        end else begin
            dl_addr[g] = a;
            dl_size[g] = sz;
            dl_req[g]  = 1'b1;
        end
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (chg && k == 0) begin
                dl_addr[g] = 32'h50;
                dl_size[g] = 2'd0;
            end
            if (is_if ? if_ack[g] : dl_ack[g]) begin
                got = 1'b1;
                chk(is_if ? "if_result" : "dl_result", g, rdata[g], exp);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout dut%0d: got no ack want ack for addr %h", g, a);
        end else begin
            @(negedge clk);
        end
        if (is_if) if_req[g] = 1'b0;
        else       dl_req[g] = 1'b0;
    endtask

    // ---------------- Directed stimulus ----------------
    initial begin
        reset   = 1'b0;
        if_req  = '0;
        dl_req  = '0;
        if_addr = '0;
        dl_addr = '0;
        dl_size = '0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_busy",  g, 32'(busy[g]),   32'd0);
            chk("rst_ack",   g, 32'({if_ack[g], dl_ack[g]}), 32'd0);
            chk("rst_rdata", g, rdata[g],      32'd0);
            chk("rst_ra",    g, rom_addr[g],   32'd0);
            chk("rst_raa",   g, rom_addr_a[g], 32'd0);
        end
        reset = 1'b1;

        // IF word, DL byte, DL half
        do_req(0, 1'b1, 32'h10, 2'd2, 32'h13121110, 1'b0);
        do_req(0, 1'b0, 32'h07, 2'd0, 32'h00000007, 1'b0);
        do_req(0, 1'b0, 32'h21, 2'd1, 32'h00002221, 1'b0);

        // Race: IF first (last grant DL), DL granted in the ack cycle
        fork
            do_req(0, 1'b1, 32'h00, 2'd2, 32'h03020100, 1'b0);
            do_req(0, 1'b0, 32'h40, 2'd2, 32'h43424140, 1'b0);
        join
        // IF alone, then a second race goes to DL
        do_req(0, 1'b1, 32'h80, 2'd2, 32'h83828180, 1'b0);
        fork
            do_req(0, 1'b1, 32'h00, 2'd2, 32'h03020100, 1'b0);
            do_req(0, 1'b0, 32'h40, 2'd2, 32'h43424140, 1'b0);
        join

        // Address wrap
        do_req(0, 1'b0, 32'hFFFFFFFE, 2'd2, 32'h0100FFFE, 1'b0);
        // Inputs changed after grant are ignored
        do_req(0, 1'b0, 32'h30, 2'd2, 32'h33323130, 1'b1);

        // Reset during BEAT1 of an IF word
        @(negedge clk);
        if_addr[0] = 32'h60;
        if_req[0]  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_busy",  0, 32'(busy[0]),   32'd0);
        chk("midrst_ack",   0, 32'(if_ack[0]), 32'd0);
        chk("midrst_rdata", 0, rdata[0],      32'd0);
        chk("midrst_ra",    0, rom_addr[0],   32'd0);
        chk("midrst_raa",   0, rom_addr_a[0], 32'd0);
        @(negedge clk);
        if_req[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        do_req(0, 1'b1, 32'h60, 2'd2, 32'h63626160, 1'b0);

        // Fixed priority: IF wins both races; reserved size fetches a word
        for (int r = 0; r < 2; r++) begin
            fork
                do_req(1, 1'b1, 32'h00, 2'd2, 32'h03020100, 1'b0);
                do_req(1, 1'b0, 32'h40, 2'd2, 32'h43424140, 1'b0);
            join
        end
        do_req(1, 1'b0, 32'h84, 2'd3, 32'h87868584, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
